// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the address and data widths, the opcode constants, the
// end-of-program marker, the fetch FSM state encodings and the fetch buffer
// entry type.
package instruction_fetch_pkg;

  localparam int PC_W    = 5;
  localparam int INSTR_W = 32;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_LI  = 4'b0101;
  localparam logic [3:0] OP_BR  = 4'b0110;

  localparam logic [INSTR_W-1:0] END_OF_PROGRAM = 32'h0;

  // Fetch FSM state encodings
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_HALT  = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: 2-entry synchronous FIFO of {pc, instruction} entries.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush_i          drop every entry (wins over push and pop)
//   push_i, entry_i  write one entry; the caller guarantees room
//   pop_i            remove the head; the caller guarantees valid_o
//   valid_o, full_o  occupancy flags
//   head_o           head entry, zero while empty
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic         full_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'(DEPTH));
  // Gate the head so stale entries never show up on an empty buffer.
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential fetch unit feeding decode.
// Drives pc into a combinational instruction memory, queues fetched words in
// a 2-entry buffer and presents them over a valid/ready handshake.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       begin fetching at RESET_PC (IDLE only)
//   pc / instruction            memory address out, memory data in
//   redirect_valid/redirect_pc  taken branch/jump target
//   out_valid/out_ready         decode handshake
//   out_instr/out_pc            head instruction and its address
//   halted                      end-of-program seen and buffer drained
//   busy                        FSM is in FETCH
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [4:0] RESET_PC = 5'd0,
  parameter int         DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               halted,
  output logic               busy
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;

  logic         buf_full, deq, redir, is_eop, room, enq;
  fetch_entry_t head;

  assign deq    = out_valid && out_ready;
  assign redir  = redirect_valid && (state_q != ST_IDLE);
  assign is_eop = (instruction == END_OF_PROGRAM);
  // A full buffer still has room when its head leaves this cycle.
  assign room   = !buf_full || deq;
  assign enq    = (state_q == ST_FETCH) && !redir && !is_eop && room;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redir) begin
      // Redirect outranks halt detection and any enqueue.
      state_d    = ST_FETCH;
      fetch_pc_d = redirect_pc;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_d    = ST_FETCH;
          fetch_pc_d = RESET_PC;
        end
        ST_FETCH: begin
          if (is_eop)   state_d    = ST_HALT;
          else if (enq) fetch_pc_d = fetch_pc_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redir),
    .push_i  (enq),
    .entry_i ('{pc: fetch_pc_q, instr: instruction}),
    .pop_i   (deq),
    .valid_o (out_valid),
    .full_o  (buf_full),
    .head_o  (head)
  );

  assign pc        = fetch_pc_q;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign halted    = (state_q == ST_HALT) && !out_valid;
  assign busy      = (state_q == ST_FETCH);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, redirect_valid, out_ready;
  logic [4:0]  pc, redirect_pc, out_pc;
  logic [31:0] instruction, out_instr;
  logic        out_valid, halted, busy;

  logic [31:0] mem [32];
  assign instruction = mem[pc];

  instruction_fetch #(.RESET_PC(5'd0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  fetch_entry_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [12:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  logic [31:0] prog [6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_prog();
    for (int i = 0; i < 6; i++) exp_q.push_back('{pc: 5'(i), instr: prog[i]});
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    for (int i = 0; i < 6; i++) mem[i] = prog[i];
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 40) begin tick(); n++; end
    check({name, " halted"}, {31'd0, halted}, 32'd1);
    check({name, " busy"}, {31'd0, busy}, 32'd0);
    check({name, " drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic redirect(input logic [4:0] tgt);
    redirect_valid = 1'b1; redirect_pc = tgt; tick(); redirect_valid = 1'b0;
  endtask

  // Monitor: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected delivery pc", {27'd0, out_pc}, 32'hFFFFFFFF);
      else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        check("deliver out_pc", {27'd0, out_pc}, {27'd0, e.pc});
        check("deliver out_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    logic [31:0] held_instr;
    logic [4:0]  held_pc;
    prog[0] = 32'h5500000A;
    prog[1] = 32'h5780000F;
    prog[2] = enc(OP_ADD, 5'd3, 5'd10, 5'd15, 13'd0);
    prog[3] = enc(OP_SUB, 5'd4, 5'd3, 5'd10, 13'd0);
    prog[4] = enc(OP_LI, 5'd5, 5'd0, 5'd0, 13'd7);
    prog[5] = enc(OP_BR, 5'd0, 5'd4, 5'd5, 13'd2);
    load_prog();
    start = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 1;
    rst_n = 1'b0;
    #1;
    check("reset out_valid", {31'd0, out_valid}, 0);
    check("reset pc", {27'd0, pc}, 0);
    check("reset out_instr", out_instr, 0);
    check("reset out_pc", {27'd0, out_pc}, 0);
    check("reset halted", {31'd0, halted}, 0);
    check("reset busy", {31'd0, busy}, 0);
    tick(); tick(); rst_n = 1'b1;

    // Straight-line program
    expect_prog();
    pulse_start();
    check("t1 busy", {31'd0, busy}, 1);
    check("t1 out_valid", {31'd0, out_valid}, 0);
    tick();
    check("t2 out_valid", {31'd0, out_valid}, 1);
    check("t2 out_pc", {27'd0, out_pc}, 0);
    wait_halt("prog");

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    tick();
    check("bp first valid", {31'd0, out_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp out_instr", out_instr, 32'h5500000A);
      check("bp out_pc", {27'd0, out_pc}, 0);
      check("bp pc hold", {27'd0, pc}, 2);
    end
    expect_prog();
    out_ready = 1'b1;
    wait_halt("bp");

    // Redirect in the same cycle as a handshake
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    tick(); tick();
    exp_q.push_back('{pc: 5'd0, instr: prog[0]});
    out_ready = 1'b1;
    tick();
    check("rd head pc", {27'd0, out_pc}, 1);
    exp_q.push_back('{pc: 5'd1, instr: prog[1]});
    exp_q.push_back('{pc: 5'd4, instr: prog[4]});
    exp_q.push_back('{pc: 5'd5, instr: prog[5]});
    redirect(5'd4);
    check("rd t1 out_valid", {31'd0, out_valid}, 0);
    check("rd t1 pc", {27'd0, pc}, 4);
    wait_halt("redirect");

    // PC wrap 30,31,0
    mem[1] = 32'h0;
    mem[30] = enc(OP_LI, 5'd1, 5'd0, 5'd0, 13'd30);
    mem[31] = enc(OP_ADD, 5'd2, 5'd1, 5'd1, 13'd0);
    exp_q.push_back('{pc: 5'd30, instr: mem[30]});
    exp_q.push_back('{pc: 5'd31, instr: mem[31]});
    exp_q.push_back('{pc: 5'd0, instr: mem[0]});
    redirect(5'd30);
    wait_halt("wrap");

    // Redirect out of HALT
    load_prog();
    expect_prog();
    redirect(5'd0);
    check("halt exit halted", {31'd0, halted}, 0);
    check("halt exit busy", {31'd0, busy}, 1);
    check("halt exit pc", {27'd0, pc}, 0);
    wait_halt("resume");

    // Asynchronous reset with a full buffer
    out_ready = 1'b0;
    redirect(5'd0);
    tick(); tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst out_valid", {31'd0, out_valid}, 0);
    check("arst pc", {27'd0, pc}, 0);
    check("arst busy", {31'd0, busy}, 0);
    check("arst halted", {31'd0, halted}, 0);
    tick(); rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    check("arst idle out_valid", {31'd0, out_valid}, 0);
    check("arst idle pc", {27'd0, pc}, 0);
    expect_prog();
    pulse_start();
    wait_halt("restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
